// File: rtl/down_counter3_pkg.sv
// Shared constants, the per-edge action encoding and its decode for the 3-bit down counter.
// Optional feature macro: DOWN_COUNTER3_AUTORELOAD_EN (borrow reloads instead of wrapping).
package down_counter3_pkg;

  localparam int unsigned CNT_W = 3;

  localparam logic [CNT_W-1:0] STEP1         = 3'd1;
  localparam logic [CNT_W-1:0] STEP2         = 3'd2;
  localparam logic [CNT_W-1:0] RESET_VAL_DEF = 3'b111;

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'b00,
    ACT_COUNT = 2'b01,
    ACT_LOAD  = 2'b10
  } action_e;

  // Load outranks count, count outranks hold.
  function automatic action_e decode_action(input logic n_load, input logic n_e);
    action_e act;
    if (!n_load) begin
      act = ACT_LOAD;
    end else if (!n_e) begin
      act = ACT_COUNT;
    end else begin
      act = ACT_HOLD;
    end
    return act;
  endfunction

endpackage : down_counter3_pkg

// File: rtl/down_counter3_step.sv
// Combinational decrement by one or two, flagging a borrow when the step passes below zero.
module down_counter3_step
  import down_counter3_pkg::*;
(
  input  logic [CNT_W-1:0] cur,
  input  logic             cntby2,
  output logic [CNT_W-1:0] nxt,
  output logic             borrow
);

  logic [CNT_W-1:0] step;

  assign step   = cntby2 ? STEP2 : STEP1;
  // Subtraction wraps naturally modulo 2**CNT_W.
  assign nxt    = CNT_W'(cur - step);
  assign borrow = (cur < step);

endmodule : down_counter3_step

// File: rtl/down_counter3.sv
// Loadable 3-bit down counter with step 1/2, registered borrow pulse and combinational zero flag.
// Define DOWN_COUNTER3_AUTORELOAD_EN to reload the last loaded value on borrow instead of wrapping.
module down_counter3
  import down_counter3_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VAL = RESET_VAL_DEF
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             nE,
  input  logic             cntby2,
  input  logic             nLoad,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] out,
  output logic             tc,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tc_q;
  logic             tc_d;
  logic [CNT_W-1:0] step_nxt;
  logic             step_borrow;
  action_e          act;

  assign act = decode_action(nLoad, nE);

  down_counter3_step u_step (
    .cur    (cnt_q),
    .cntby2 (cntby2),
    .nxt    (step_nxt),
    .borrow (step_borrow)
  );

`ifdef DOWN_COUNTER3_AUTORELOAD_EN
  logic [CNT_W-1:0] reload_q;
  logic [CNT_W-1:0] reload_d;

  // Next-state: a borrowing count restarts from the last loaded value.
  always_comb begin
    cnt_d    = cnt_q;
    tc_d     = 1'b0;
    reload_d = reload_q;
    unique case (act)
      ACT_LOAD: begin
        cnt_d    = din;
        reload_d = din;
      end
      ACT_COUNT: begin
        tc_d  = step_borrow;
        cnt_d = step_borrow ? reload_q : step_nxt;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      reload_q <= RESET_VAL;
    end else begin
      reload_q <= reload_d;
    end
  end
`else
  // Next-state: a borrowing count simply wraps.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    unique case (act)
      ACT_LOAD: begin
        cnt_d = din;
      end
      ACT_COUNT: begin
        tc_d  = step_borrow;
        cnt_d = step_nxt;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end
`endif

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q <= RESET_VAL;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign out  = cnt_q;
  assign tc   = tc_q;
  assign zero = (cnt_q == '0);

endmodule : down_counter3

// File: tb/tb_down_counter3.sv
// Self-checking bench for down_counter3: directed scenarios plus randomized traffic against an integer model.
module tb_down_counter3;

  logic       Clk;
  logic       nReset;
  logic       nE;
  logic       cntby2;
  logic       nLoad;
  logic [2:0] din;
  logic [2:0] out;
  logic       tc;
  logic       zero;

  int n_checks;
  int n_errors;
  bit chk_en;

  int m_out;
  int m_reload;
  int m_tc;
  int m_step;
  int m_v;

`ifdef DOWN_COUNTER3_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  down_counter3 dut (
    .Clk    (Clk),
    .nReset (nReset),
    .nE     (nE),
    .cntby2 (cntby2),
    .nLoad  (nLoad),
    .din    (din),
    .out    (out),
    .tc     (tc),
    .zero   (zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic straight from the load/count/hold rules.
  always @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      m_out = 7; m_reload = 7; m_tc = 0;
    end else if (!nLoad) begin
      m_out = int'(din); m_reload = int'(din); m_tc = 0;
    end else if (!nE) begin
      m_step = cntby2 ? 2 : 1;
      m_v    = m_out - m_step;
      m_tc   = (m_v < 0) ? 1 : 0;
      if (m_v < 0) m_v = AUTORELOAD ? m_reload : m_v + 8;
      m_out  = m_v;
    end else begin
      m_tc = 0;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("model_out",  {1'b0, out},   4'(m_out));
      chk("model_tc",   {3'b0, tc},    4'(m_tc));
      chk("model_zero", {3'b0, zero},  (m_out == 0) ? 4'd1 : 4'd0);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; chk_en = 1'b0;
    nReset = 1'b1; nE = 1'b1; cntby2 = 1'b0; nLoad = 1'b1; din = 3'd0;

    // Reset: asynchronous, edges ignored while low.
    #2 nReset = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_out_async", {1'b0, out}, 4'd7);
    chk("rst_tc_async",  {3'b0, tc},  4'd0);
    nE = 1'b0;
    tick(); tick();
    chk("rst_out_hold", {1'b0, out}, 4'd7);
    chk("rst_tc_hold",  {3'b0, tc},  4'd0);
    #2 nReset = 1'b1;

    // Step-1 counting from reset value.
    nE = 1'b0; cntby2 = 1'b0;
    tick(); chk("cnt1_a", {1'b0, out}, 4'd6); chk("model_pin_a", 4'(m_out), 4'd6);
    tick(); chk("cnt1_b", {1'b0, out}, 4'd5);
    tick(); chk("cnt1_c", {1'b0, out}, 4'd4);
    tick(); chk("cnt1_d", {1'b0, out}, 4'd3); chk("cnt1_tc", {3'b0, tc}, 4'd0);
    chk("model_pin_b", 4'(m_out), 4'd3);

    // Load 1 then count by 2 through the borrow.
    nLoad = 1'b0; din = 3'd1; nE = 1'b1;
    tick(); chk("ld1_out", {1'b0, out}, 4'd1); chk("ld1_tc", {3'b0, tc}, 4'd0);
    nLoad = 1'b1; nE = 1'b0; cntby2 = 1'b1;
    tick();
    chk("by2_wrap_out", {1'b0, out}, AUTORELOAD ? 4'd1 : 4'd7);
    chk("by2_wrap_tc",  {3'b0, tc},  4'd1);
    tick();
    chk("by2_next_out", {1'b0, out}, AUTORELOAD ? 4'd1 : 4'd5);
    chk("by2_next_tc",  {3'b0, tc},  AUTORELOAD ? 4'd1 : 4'd0);

    // Load wins over count, then hold.
    nLoad = 1'b0; din = 3'd4; nE = 1'b0;
    tick(); chk("ld_wins", {1'b0, out}, 4'd4);
    nLoad = 1'b1; nE = 1'b1;
    tick(); chk("hold_out", {1'b0, out}, 4'd4); chk("hold_tc", {3'b0, tc}, 4'd0);

    // Zero flag and step-1 borrow from zero.
    nLoad = 1'b0; din = 3'd0;
    tick(); chk("zero_set", {3'b0, zero}, 4'd1);
    nLoad = 1'b1; nE = 1'b0; cntby2 = 1'b0;
    tick();
    chk("z_wrap_out",  {1'b0, out},  AUTORELOAD ? 4'd0 : 4'd7);
    chk("z_wrap_tc",   {3'b0, tc},   4'd1);
    chk("z_wrap_zero", {3'b0, zero}, AUTORELOAD ? 4'd1 : 4'd0);

    // Step select sampled only at the edge, glitches ignored.
    nLoad = 1'b0; din = 3'd6; nE = 1'b1;
    tick();
    nLoad = 1'b1; nE = 1'b0; cntby2 = 1'b1;
    tick(); chk("sel_by2", {1'b0, out}, 4'd4);
    cntby2 = 1'b0;
    #2 cntby2 = 1'b1;
    #1 cntby2 = 1'b0;
    tick(); chk("sel_by1", {1'b0, out}, 4'd3);

    // Reset mid-count.
    #2 nReset = 1'b0;
    #1 chk("rst_mid_out", {1'b0, out}, 4'd7); chk("rst_mid_tc", {3'b0, tc}, 4'd0);
    tick(); chk("rst_mid_ign", {1'b0, out}, 4'd7);
    #2 nReset = 1'b1;

    // Randomized traffic checked by the model on every negedge.
    for (int i = 0; i < 400; i++) begin
      tick();
      nLoad  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      nE     = 1'($urandom_range(0, 1));
      cntby2 = 1'($urandom_range(0, 1));
      din    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        #2 cntby2 = ~cntby2;
        #1 cntby2 = ~cntby2;
      end else if ($urandom_range(0, 39) == 0) begin
        #1 nReset = 1'b0;
        #2 nReset = 1'b1;
      end
    end

    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_down_counter3

// File: doc/down_counter3.md
DOWN_COUNTER3 -- requirements
Module: down_counter3

Interface
REQ-001 SHALL provide parameter RESET_VAL, default 3'b111, value loaded into out and the reload register on reset.
REQ-002 SHALL provide port Clk, input, 1, sole clock; all state changes on rising edge.
REQ-003 SHALL provide port nReset, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL provide port nE, input, 1, count enable; active-low.
REQ-005 SHALL provide port cntby2, input, 1, step select; high = step 2, low = step 1.
REQ-006 SHALL provide port nLoad, input, 1, synchronous parallel load; active-low.
REQ-007 SHALL provide port din, input, 3, parallel load value.
REQ-008 SHALL provide port out, output, 3, registered count value.
REQ-009 SHALL provide port tc, output, 1, registered terminal-count (borrow) pulse.
REQ-010 SHALL provide port zero, output, 1, combinational (out == 3'b000).

Function
REQ-011 Each rising Clk edge SHALL apply exactly one action, highest priority first: load, count, hold.
REQ-012 nLoad low SHALL set out <= din and reload register <= din, regardless of nE and cntby2.
REQ-013 nLoad high, nE low SHALL set out <= (out - step) mod 8, step = 2 if cntby2 else 1.
REQ-014 nLoad high, nE high SHALL hold out; tc <= 0.
REQ-015 Borrow SHALL be true on a count edge when out < step: 0->7 (step 1), 1->7 and 0->6 (step 2).
REQ-016 tc SHALL be 1 for exactly the one cycle following a count edge with borrow, otherwise 0; a load edge SHALL drive tc <= 0.
REQ-017 cntby2 and nE SHALL be sampled only at the rising edge; mid-cycle changes SHALL have no effect.
REQ-018 Latency: out and tc SHALL reflect an edge's action one clock-to-q after that edge; zero follows out combinationally.
REQ-019 Consecutive count edges SHALL step on every edge with no dead cycles, including across a wrap.

Reset
REQ-020 nReset low SHALL immediately force out = RESET_VAL, reload register = RESET_VAL, tc = 0, independent of Clk.
REQ-021 While nReset is low, all edges SHALL be ignored; the first rising edge after nReset rises SHALL act normally.
REQ-022 Reset asserted mid-count or mid-load SHALL abandon that operation with no partial update.

Configuration
REQ-023 With DOWN_COUNTER3_AUTORELOAD_EN defined, a borrowing count edge SHALL set out <= reload register instead of the wrapped value; tc behaves per REQ-016.
REQ-024 Without DOWN_COUNTER3_AUTORELOAD_EN, a borrow SHALL wrap mod 8 per REQ-013; the reload register SHALL be omitted.

Structure
REQ-025 Package down_counter3_pkg SHALL hold CNT_W = 3, STEP1 = 3'd1, STEP2 = 3'd2, and the default RESET_VAL constant.
REQ-026 Sub-module down_counter3_step SHALL be combinational: inputs cur[2:0] and cntby2; outputs nxt[2:0] and borrow. The parent SHALL hold all registers.

Verification (10-unit clock period; count edges with nLoad high)
REQ-027 nReset low at t=15, high at t=45 -> out = 3'b111 from t=15, unchanged by edges at 25 and 35, and tc = 0.
REQ-028 Reset released; nE low, cntby2 = 0, four edges -> out = 6, 5, 4, 3; tc stays 0.
REQ-029 Load din = 1, then nE low, cntby2 = 1 -> out = 1, then 7 with tc = 1 for one cycle, then 5 with tc = 0. With the macro defined, the sequence is 1, then 1 with tc = 1.
REQ-030 nLoad low, din = 4, nE low on the same edge -> out = 4 (load wins); the next edge with nE high -> out holds at 4.
REQ-031 out = 0, cntby2 = 0, nE low -> out = 7 and tc pulses; zero = 1 only while out = 0.
REQ-032 cntby2 toggled between edges at out = 6 -> each step uses the value sampled at its edge, for example 6 -> 4 (cntby2 = 1), then 3 (cntby2 = 0).
